instr_fetch: RTL and testbench

Instruction fetch stage feeding the control unit. Holds the program counter, fetches one instruction word per request/acknowledge handshake from instruction memory, and latches it in an instruction register. Presents the 6-bit `opCode` and operand to the control unit and resolves next-PC selection, including a small return-address stack for `jmp`/`ret`. It sits directly upstream of the control unit; the datapath's `next` strobe returns to this block as `advance`.

---
 rtl/instr_fetch_if.sv | 13 +
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus between the fetch stage (master) and the
// instruction memory (slave).
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [ADDR_W+5:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, instruction register, memory handshake and
// next-PC resolution with a small return-address stack for jmp/ret.
module instr_fetch #(
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     mem,
  input  logic              advance,
  input  logic              cond_taken,
  output logic [5:0]        opCode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              stack_err
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH);

  localparam logic [5:0] OpBra = 6'b000110;
  localparam logic [5:0] OpJmp = 6'b000111;
  localparam logic [5:0] OpRet = 6'b001000;

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [PtrW:0]     count_q;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              push;
  logic              pop;
  logic              stack_full;
  logic              stack_empty;
  logic [PtrW-1:0]   top_idx;

  // Natural overflow of the ADDR_W-bit add gives the 1023 -> 0 wrap.
  assign pc_inc      = pc + ADDR_W'(1);
  assign stack_full  = (count_q == (PtrW + 1)'(STACK_DEPTH));
  assign stack_empty = (count_q == '0);
  assign top_idx     = PtrW'(count_q - 1'b1);
  assign mem.addr    = pc;

  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    case (opCode)
      OpBra: next_pc = operand;
      OpJmp: begin
        push    = 1'b1;
        next_pc = operand;
      end
      OpRet: begin
        pop     = 1'b1;
        next_pc = stack_empty ? RESET_PC : stack_q[top_idx];
      end
      6'd0, 6'd1, 6'd2, 6'd3: begin
        if (cond_taken) next_pc = operand;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc          <= RESET_PC;
      opCode      <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
      mem.req     <= 1'b0;
      stack_err   <= 1'b0;
      count_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          mem.req <= 1'b1;
        end
        StFetch: begin
          if (mem.ack) begin
            opCode      <= mem.rdata[ADDR_W+5:ADDR_W];
            operand     <= mem.rdata[ADDR_W-1:0];
            mem.req     <= 1'b0;
            instr_valid <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (advance) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            mem.req     <= 1'b1;
            state_q     <= StFetch;
            // A push on a full stack leaves its contents untouched; the jump is still taken.
            if (push) begin
              if (stack_full) begin
                stack_err <= 1'b1;
              end else begin
                stack_q[count_q[PtrW-1:0]] <= pc_inc;
                count_q                    <= count_q + 1'b1;
              end
            end
            if (pop) begin
              if (stack_empty) stack_err <= 1'b1;
              else             count_q   <= count_q - 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, wait states, branches,
// call/return stack, stack errors, PC wrap and reset during a fetch.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       advance = 1'b0;
  logic       cond_taken = 1'b0;
  logic [5:0] opCode;
  logic [9:0] operand;
  logic [9:0] pc;
  logic       instr_valid;
  logic       stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_arr [1024];
  int          wait_n    = 0;
  int          wcnt      = 0;
  logic        auto_mem  = 1'b1;
  logic        man_ack   = 1'b0;
  logic [15:0] man_rdata = '0;

  instr_fetch_if #(.ADDR_W(10)) mem_if ();

  instr_fetch #(
    .ADDR_W     (10),
    .STACK_DEPTH(4),
    .RESET_PC   (10'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem_if),
    .advance    (advance),
    .cond_taken (cond_taken),
    .opCode     (opCode),
    .operand    (operand),
    .pc         (pc),
    .instr_valid(instr_valid),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  // Memory model: acks after wait_n request cycles, or follows manual values.
  always @(negedge clk) begin
    if (!auto_mem) begin
      mem_if.ack   = man_ack;
      mem_if.rdata = man_rdata;
    end else if (rst || !mem_if.req || mem_if.ack) begin
      mem_if.ack = 1'b0;
      wcnt       = 0;
    end else if (wcnt == wait_n) begin
      mem_if.ack   = 1'b1;
      mem_if.rdata = mem_arr[mem_if.addr];
    end else begin
      wcnt++;
    end
  end

  function automatic logic [15:0] ins(input logic [5:0] op, input logic [9:0] a);
    return {op, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_hold(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  // Advance out of HOLD and check the next fetch is requested at exp_addr.
  task automatic step(input string tag, input logic c, input logic [9:0] exp_addr);
    wait_hold(tag);
    advance    = 1'b1;
    cond_taken = c;
    @(negedge clk);
    advance    = 1'b0;
    cond_taken = 1'b0;
    check({tag, "_req"},   32'(mem_if.req),  32'd1);
    check({tag, "_addr"},  32'(mem_if.addr), 32'(exp_addr));
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(mem_if.req),  32'd0);
    check({tag, "_addr"},  32'(mem_if.addr), 32'd0);
    check({tag, "_pc"},    32'(pc),          32'd0);
    check({tag, "_op"},    32'(opCode),      32'd0);
    check({tag, "_opnd"},  32'(operand),     32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_err"},   32'(stack_err),   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = ins(6'd9, 10'd0);
    mem_arr[10'h000] = ins(6'b001001, 10'h011);
    mem_arr[10'h001] = ins(6'b001010, 10'h022);
    mem_arr[10'h002] = ins(6'b000100, 10'h033);
    mem_arr[10'h003] = ins(6'b000110, 10'h010);
    mem_arr[10'h010] = ins(6'b000000, 10'h100);
    mem_arr[10'h011] = ins(6'b000110, 10'h010);
    mem_arr[10'h100] = ins(6'b000110, 10'h050);
    mem_arr[10'h050] = ins(6'b000110, 10'h020);
    mem_arr[10'h020] = ins(6'b000111, 10'h200);
    mem_arr[10'h200] = ins(6'b001000, 10'h000);
    mem_arr[10'h021] = ins(6'b000111, 10'h040);
    mem_arr[10'h040] = ins(6'b000111, 10'h060);
    mem_arr[10'h060] = ins(6'b000111, 10'h070);
    mem_arr[10'h070] = ins(6'b000111, 10'h080);
    mem_arr[10'h080] = ins(6'b001000, 10'h000);
    mem_arr[10'h071] = ins(6'b001000, 10'h000);
    mem_arr[10'h061] = ins(6'b001000, 10'h000);
    mem_arr[10'h041] = ins(6'b001000, 10'h000);
    mem_arr[10'h022] = ins(6'b000111, 10'h090);
    mem_arr[10'h090] = ins(6'b000111, 10'h0A0);
    mem_arr[10'h0A0] = ins(6'b000111, 10'h0B0);
    mem_arr[10'h0B0] = ins(6'b000111, 10'h0C0);
    mem_arr[10'h0C0] = ins(6'b000111, 10'h0D0);
    mem_arr[10'h0D0] = ins(6'b001000, 10'h000);

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    check("first_req", 32'(mem_if.req), 32'd1);
    check("first_addr", 32'(mem_if.addr), 32'd0);
    check("first_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(instr_valid), 32'd1);
    check("seq0_op", 32'(opCode), 32'h09);

    step("seq1", 1'b0, 10'h001);
    wait_hold("seq1h");
    check("seq1_op", 32'(opCode), 32'h0A);

    // Three wait states on the fetch of address 2.
    wait_n = 3;
    step("seq2", 1'b0, 10'h002);
    for (int k = 0; k < 3; k++) begin
      check("ws_req", 32'(mem_if.req), 32'd1);
      check("ws_addr", 32'(mem_if.addr), 32'd2);
      check("ws_valid", 32'(instr_valid), 32'd0);
      check("ws_op", 32'(opCode), 32'h0A);
      @(negedge clk);
    end
    check("ws_valid_ack", 32'(instr_valid), 32'd0);
    wait_hold("seq2h");
    wait_n = 0;
    check("seq2_op", 32'(opCode), 32'h04);
    check("seq2_opnd", 32'(operand), 32'h033);

    step("seq3", 1'b0, 10'h003);
    step("bra", 1'b0, 10'h010);
    step("brz_nt", 1'b0, 10'h011);
    step("bra_back", 1'b0, 10'h010);
    step("brz_t", 1'b1, 10'h100);
    step("bra050", 1'b0, 10'h050);
    step("to020", 1'b0, 10'h020);
    step("jmp", 1'b0, 10'h200);
    step("ret", 1'b0, 10'h021);

    step("nest1", 1'b0, 10'h040);
    step("nest2", 1'b0, 10'h060);
    step("nest3", 1'b0, 10'h070);
    step("nest4", 1'b0, 10'h080);
    step("unw1", 1'b0, 10'h071);
    step("unw2", 1'b0, 10'h061);
    step("unw3", 1'b0, 10'h041);
    step("unw4", 1'b0, 10'h022);
    check("nest_err", 32'(stack_err), 32'd0);

    step("ov1", 1'b0, 10'h090);
    step("ov2", 1'b0, 10'h0A0);
    step("ov3", 1'b0, 10'h0B0);
    step("ov4", 1'b0, 10'h0C0);
    check("full_err", 32'(stack_err), 32'd0);
    step("ov5", 1'b0, 10'h0D0);
    check("ovf_err", 32'(stack_err), 32'd1);
    step("ovf_top", 1'b0, 10'h0B1);

    // Reset clears the sticky error; then underflow from an empty stack.
    wait_hold("prerst");
    mem_arr[10'h000] = ins(6'b001000, 10'h000);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_err", 32'(stack_err), 32'd0);
    rst = 1'b0;
    wait_hold("uf");
    check("uf_op", 32'(opCode), 32'h08);
    mem_arr[10'h000] = ins(6'b000110, 10'h3FF);
    step("uf_ret", 1'b0, 10'h000);
    check("uf_err", 32'(stack_err), 32'd1);
    step("to3ff", 1'b0, 10'h3FF);
    check("uf_err_hold", 32'(stack_err), 32'd1);

    // Wrap at 1023, then reset during the fetch with a late ack present.
    wait_hold("wraph");
    auto_mem  = 1'b0;
    man_ack   = 1'b1;
    man_rdata = ins(6'b111111, 10'h3AB);
    step("wrap", 1'b0, 10'h000);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    man_ack  = 1'b0;
    auto_mem = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_req", 32'(mem_if.req), 32'd1);
    check("rel_addr", 32'(mem_if.addr), 32'd0);
    wait_hold("relh");
    check("rel_op", 32'(opCode), 32'h06);
    check("rel_opnd", 32'(operand), 32'h3FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
